fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter_if.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 128 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between n_req valid/ready requesters, the round-robin
// arbiter and the FIFO write port. The arbiter uses the slave modport.
interface fifo_wr_arbiter_if #(
  parameter int n_req   = 4,
  parameter int d_width = 16
);
  localparam int ID_W = $clog2(n_req);

  logic [n_req-1:0]         req_valid;
  logic [n_req*d_width-1:0] req_data;
  logic [n_req-1:0]         req_ready;
  logic                     fifo_full;
  logic                     wr_en;
  logic [d_width-1:0]       wr_data;
  logic [ID_W-1:0]          grant_id;
  logic                     busy;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, wr_en, wr_data, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, wr_en, wr_data, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between n_req requesters.
// Define FIFO_ARB_BURST_EN for up to burst_len beats per grant; otherwise one beat per grant.
module fifo_wr_arbiter #(
  parameter int n_req     = 4,
  parameter int d_width   = 16,
  parameter int burst_len = 4
) (
  input logic               Clk,
  input logic               Reset,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int ID_W = $clog2(n_req);

  if (n_req < 2) begin : g_bad_n_req
    $error("fifo_wr_arbiter: n_req must be at least 2");
  end
  if (burst_len < 1) begin : g_bad_burst_len
    $error("fifo_wr_arbiter: burst_len must be at least 1");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] grant_reg, grant_nxt;
  logic [ID_W-1:0] last, last_nxt;
  logic            xfer;
  logic [d_width-1:0] req_word [n_req];

`ifdef FIFO_ARB_BURST_EN
  localparam int CNT_W = $clog2(burst_len + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(burst_len - 1);
  logic [CNT_W-1:0] beat_cnt, cnt_nxt;
`endif

  for (genvar i = 0; i < n_req; i++) begin : g_word
    assign req_word[i] = bus.req_data[i*d_width +: d_width];
  end

  // First valid requester searching circularly from prev+1, wrapping n_req-1 -> 0.
  function automatic logic [ID_W-1:0] rr_pick(input logic [n_req-1:0] v,
                                               input logic [ID_W-1:0]  prev);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    logic            found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= n_req; k++) begin
      idx = ID_W'((int'(prev) + k) % n_req);
      if (!found && v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      grant_reg <= '0;
      last      <= ID_W'(n_req - 1);
`ifdef FIFO_ARB_BURST_EN
      beat_cnt  <= '0;
`endif
    end else begin
      state     <= state_nxt;
      grant_reg <= grant_nxt;
      last      <= last_nxt;
`ifdef FIFO_ARB_BURST_EN
      beat_cnt  <= cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant_reg;
    last_nxt      = last;
`ifdef FIFO_ARB_BURST_EN
    cnt_nxt       = beat_cnt;
`endif
    xfer          = 1'b0;
    bus.req_ready = '0;
    bus.wr_en     = 1'b0;
    bus.wr_data   = '0;

    unique case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          grant_nxt = rr_pick(bus.req_valid, last);
          state_nxt = GRANT;
`ifdef FIFO_ARB_BURST_EN
          cnt_nxt   = '0;
`endif
        end
      end
      GRANT: begin
        // Outputs follow fifo_full combinationally so a write never sees a stale flag.
        bus.req_ready[grant_reg] = ~bus.fifo_full;
        bus.wr_data              = req_word[grant_reg];
        xfer                     = bus.req_valid[grant_reg] & ~bus.fifo_full;
        bus.wr_en                = xfer;

        if (!bus.req_valid[grant_reg]) begin
          state_nxt = IDLE;
          last_nxt  = grant_reg;
        end else if (xfer) begin
`ifdef FIFO_ARB_BURST_EN
          cnt_nxt = beat_cnt + CNT_W'(1);
          if (beat_cnt == LAST_BEAT) begin
            state_nxt = IDLE;
            last_nxt  = grant_reg;
          end
`else
          state_nxt = IDLE;
          last_nxt  = grant_reg;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.grant_id = grant_reg;
  assign bus.busy     = (state == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester queues drive the DUT and a
// scoreboard of (grant, data, cycle) predicted from the arbitration rules checks each write.
module tb_fifo_wr_arbiter;

  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int BLEN = 4;
`ifdef FIFO_ARB_BURST_EN
  localparam int BL = BLEN;
`else
  localparam int BL = 1;
`endif

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  fifo_wr_arbiter_if #(.n_req(N), .d_width(DW)) bus ();

  fifo_wr_arbiter #(.n_req(N), .d_width(DW), .burst_len(BLEN)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  id;
    logic [15:0] data;
    int          stamp;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] src [N][32];
  int          src_n  [N];
  int          src_rd [N];
  int          cyc, t0, nwr, m_last;
  int          npass, nchk, nfail;
  bit          chk_stamp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    nchk++;
    assert (got === want) npass++;
    else begin
      nfail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = (src_rd[i] < src_n[i]);
      bus.req_data[i*DW +: DW] = (src_rd[i] < src_n[i]) ? src[i][src_rd[i]] : 16'hDEAD;
    end
  endtask

  task automatic load(input int id, input logic [15:0] base, input int n);
    if (src_rd[id] == src_n[id]) begin
      src_rd[id] = 0;
      src_n[id]  = 0;
    end
    for (int k = 0; k < n; k++) src[id][src_n[id] + k] = base + 16'(k);
    src_n[id] += n;
  endtask

  // Predicted write order and cycle of every beat, all loaded requesters held valid.
  task automatic plan();
    int rem [N];
    int pos [N];
    int t, id, r;
    bit any;
    t = 0;
    for (int i = 0; i < N; i++) begin
      rem[i] = src_n[i] - src_rd[i];
      pos[i] = src_rd[i];
    end
    any = 1'b1;
    while (any) begin
      id = -1;
      for (int k = 1; k <= N; k++)
        if (id < 0 && rem[(m_last + k) % N] > 0) id = (m_last + k) % N;
      if (id < 0) begin
        any = 1'b0;
      end else begin
        r = (rem[id] < BL) ? rem[id] : BL;
        for (int b = 1; b <= r; b++)
          sb.push_back('{id: 2'(id), data: src[id][pos[id] + b - 1], stamp: t + b});
        pos[id] += r;
        rem[id] -= r;
        t += r + 1 + ((r < BL) ? 1 : 0);
        m_last = id;
      end
    end
  endtask

  task automatic tick();
    exp_t       e;
    logic [N-1:0] acc;
    @(negedge Clk);
    acc = bus.req_ready & bus.req_valid;
    if (bus.fifo_full) begin
      check("full_wr_en", 32'(bus.wr_en), 0);
      check("full_req_ready", 32'(bus.req_ready), 0);
    end
    if (bus.wr_en === 1'b1) begin
      nwr++;
      if (sb.size() == 0) begin
        check("spurious_wr_en", 32'(bus.wr_en), 0);
      end else begin
        e = sb.pop_front();
        check("wr_grant_id", 32'(bus.grant_id), 32'(e.id));
        check("wr_data", 32'(bus.wr_data), 32'(e.data));
        check("wr_req_ready", 32'(bus.req_ready), 32'(4'b0001 << e.id));
        if (chk_stamp) check("wr_cycle", 32'(cyc - t0), 32'(e.stamp));
      end
    end
    @(posedge Clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (acc[i]) src_rd[i]++;
    drive();
  endtask

  task automatic begin_scn();
    t0        = cyc;
    nwr       = 0;
    chk_stamp = 1'b1;
    plan();
    drive();
  endtask

  task automatic run(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 32'(sb.size()), 0);
    sb.delete();
    tick();
    tick();
    check({name, "_idle_busy"}, 32'(bus.busy), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"}, 32'(bus.busy), 0);
    check({name, "_grant_id"}, 32'(bus.grant_id), 0);
    check({name, "_req_ready"}, 32'(bus.req_ready), 0);
    check({name, "_wr_en"}, 32'(bus.wr_en), 0);
    check({name, "_wr_data"}, 32'(bus.wr_data), 0);
  endtask

  initial begin
    int n;
    Reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    cyc = 0; npass = 0; nchk = 0; nfail = 0; m_last = N - 1;
    for (int i = 0; i < N; i++) begin
      src_n[i]  = 0;
      src_rd[i] = 0;
    end

    // Reset held with every requester valid, then all continuously valid.
    load(0, 16'h0000, 8);
    load(1, 16'h1000, 4);
    load(2, 16'h2000, 4);
    load(3, 16'h3000, 4);
    drive();
    repeat (3) @(posedge Clk);
    #1;
    check_reset_outputs("rst_all_valid");
    Reset = 1'b0;
    begin_scn();
    run("all_valid", 200);

    // Lone requester 2 with ten beats.
    load(2, 16'h0000, 10);
    begin_scn();
    run("single_req", 200);

    // FIFO full for five cycles right after beat 2.
    load(2, 16'h0100, 4);
    begin_scn();
    chk_stamp = 1'b0;
    n = 0;
    while (nwr < 2 && n < 20) begin
      tick();
      n++;
    end
    check("full_setup_beats", 32'(nwr), 2);
    bus.fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k >= 1) begin
        check("full_hold_busy", 32'(bus.busy), 1);
        check("full_hold_grant", 32'(bus.grant_id), 2);
      end
    end
    bus.fifo_full = 1'b0;
    run("full_resume", 100);

    // Requester 1 drops valid after one beat; requester 2 follows.
    load(1, 16'h0400, 1);
    load(2, 16'h0500, 2);
    begin_scn();
    run("drop_valid", 100);

    // Requesters 0 and 3 alternate.
    load(0, 16'h0A00, 4);
    load(3, 16'h0D00, 4);
    begin_scn();
    run("req0_req3", 200);

    // Reset asserted mid-burst, then priority restarts at requester 0.
    load(1, 16'h0600, 8);
    load(0, 16'h0610, 2);
    begin_scn();
    n = 0;
    while (nwr < 2 && n < 20) begin
      tick();
      n++;
    end
    check("midrst_setup_beats", 32'(nwr), 2);
    #3;
    Reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid_burst");
    sb.delete();
    for (int i = 0; i < N; i++) begin
      src_n[i]  = 0;
      src_rd[i] = 0;
    end
    m_last = N - 1;
    drive();
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    load(1, 16'h0700, 1);
    load(0, 16'h0710, 1);
    begin_scn();
    run("after_reset", 100);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", nchk);
    $fatal(1, "timeout");
  end

endmodule
